gpo_pad_ctrl: RTL and testbench

GPO_PAD_CTRL -- requirements
Module: gpo_pad_ctrl

---
 rtl/gpo_pad_ctrl_if.sv | 21 ++
 rtl/gpo_pad_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gpo_pad_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpo_pad_ctrl_if.sv
// Configuration request channel of the GPO pad controller.
// The requester drives the request fields; the controller returns ready.
interface gpo_pad_ctrl_if;
    logic       CFG_VALID_I;
    logic       CFG_READY_O;
    logic [3:0] CFG_DS_I;
    logic       CFG_SR_I;
    logic       CFG_CO_I;
    logic [1:0] CFG_MODE_I;
    logic       CFG_EN_I;

    modport master (
        output CFG_VALID_I, CFG_DS_I, CFG_SR_I, CFG_CO_I, CFG_MODE_I, CFG_EN_I,
        input  CFG_READY_O
    );

    modport slave (
        input  CFG_VALID_I, CFG_DS_I, CFG_SR_I, CFG_CO_I, CFG_MODE_I, CFG_EN_I,
        output CFG_READY_O
    );
endinterface

// File: rtl/gpo_pad_ctrl.sv
// GPO pad reconfiguration sequencer: tri-states the pad, applies a new drive
// setting, waits for VBIAS when strong drive is requested, then re-enables.
module gpo_pad_ctrl #(
    parameter int unsigned GUARD_CYC = 4,
    parameter int unsigned VB_TO     = 64
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    gpo_pad_ctrl_if.slave      cfg,
    input  logic               DATA_I,
    input  logic               VBIAS_OK_I,
    output logic               DO_O,
    output logic [3:0]         DS_O,
    output logic               SR_O,
    output logic               CO_O,
    output logic               OE_O,
    output logic               ODP_O,
    output logic               ODN_O,
    output logic               BUSY_O,
    output logic               ERR_O
);

    typedef enum logic [2:0] {
        IDLE,
        GOFF,
        APPLY,
        VBWAIT,
        GON
    } state_t;

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYC);
    localparam logic [7:0] VB_LD    = 8'(VB_TO);

    state_t     state;
    logic [7:0] cnt;
    logic       ready_q;
    logic       vb_m;
    logic       vb_s;
    logic [3:0] cap_ds;
    logic       cap_sr;
    logic       cap_co;
    logic [1:0] cap_mode;
    logic       cap_en;
    logic       drive_ok;

    assign cfg.CFG_READY_O = ready_q & ~RST_I;
    assign drive_ok        = cap_en & (cap_mode != 2'b11);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            vb_m <= 1'b0;
            vb_s <= 1'b0;
            DO_O <= 1'b0;
        end else begin
            vb_m <= VBIAS_OK_I;
            vb_s <= vb_m;
            DO_O <= DATA_I;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_q  <= 1'b0;
            BUSY_O   <= 1'b0;
            ERR_O    <= 1'b0;
            OE_O     <= 1'b0;
            DS_O     <= '0;
            SR_O     <= 1'b0;
            CO_O     <= 1'b0;
            ODP_O    <= 1'b0;
            ODN_O    <= 1'b0;
            cap_ds   <= '0;
            cap_sr   <= 1'b0;
            cap_co   <= 1'b0;
            cap_mode <= '0;
            cap_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg.CFG_VALID_I && ready_q) begin
                        cap_ds   <= cfg.CFG_DS_I;
                        cap_sr   <= cfg.CFG_SR_I;
                        cap_co   <= cfg.CFG_CO_I;
                        cap_mode <= cfg.CFG_MODE_I;
                        cap_en   <= cfg.CFG_EN_I;
                        ERR_O    <= 1'b0;
                        OE_O     <= 1'b0;
                        ready_q  <= 1'b0;
                        BUSY_O   <= 1'b1;
                        cnt      <= GUARD_LD;
                        state    <= GOFF;
                    end else begin
                        ready_q <= 1'b1;
                        // strong drive without bias: disable until reconfigured
                        if (OE_O && (DS_O[1:0] != 2'b00) && !vb_s) begin
                            OE_O  <= 1'b0;
                            ERR_O <= 1'b1;
                        end
                    end
                end
                GOFF: begin
                    // acceptance cycle drops OE, then GUARD_CYC guard cycles
                    if (cnt == 8'd0) begin
                        DS_O  <= cap_ds;
                        SR_O  <= cap_sr;
                        CO_O  <= cap_co;
                        ODP_O <= (cap_mode == 2'b01);
                        ODN_O <= (cap_mode == 2'b10);
                        state <= APPLY;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                APPLY: begin
                    if (cap_ds[1:0] == 2'b00) begin
                        cnt   <= GUARD_LD;
                        state <= GON;
                    end else begin
                        cnt   <= VB_LD;
                        state <= VBWAIT;
                    end
                end
                VBWAIT: begin
                    if (vb_s) begin
                        cnt   <= GUARD_LD;
                        state <= GON;
                    end else if (cnt <= 8'd1) begin
                        DS_O[1:0] <= 2'b00;
                        ERR_O     <= 1'b1;
                        cnt       <= GUARD_LD;
                        state     <= GON;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GON: begin
                    if (cnt <= 8'd1) begin
                        OE_O    <= drive_ok & ((DS_O[1:0] == 2'b00) | vb_s);
                        if (drive_ok && (DS_O[1:0] != 2'b00) && !vb_s) begin
                            ERR_O <= 1'b1;
                        end
                        BUSY_O  <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    BUSY_O  <= 1'b0;
                    ready_q <= 1'b0;
                    OE_O    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Bench for gpo_pad_ctrl: directed scenarios plus random requests, checked
// against an event-time model of the reconfiguration sequence.
module tb_gpo_pad_ctrl;

    localparam int G   = 4;
    localparam int VBT = 64;
    localparam int BIG = 1 << 30;

    logic       CLK_I;
    logic       RST_I;
    logic       DATA_I;
    logic       VBIAS_OK_I;
    logic       DO_O;
    logic [3:0] DS_O;
    logic       SR_O;
    logic       CO_O;
    logic       OE_O;
    logic       ODP_O;
    logic       ODN_O;
    logic       BUSY_O;
    logic       ERR_O;

    gpo_pad_ctrl_if cfg_if ();

    gpo_pad_ctrl #(.GUARD_CYC(G), .VB_TO(VBT)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .cfg        (cfg_if),
        .DATA_I     (DATA_I),
        .VBIAS_OK_I (VBIAS_OK_I),
        .DO_O       (DO_O),
        .DS_O       (DS_O),
        .SR_O       (SR_O),
        .CO_O       (CO_O),
        .OE_O       (OE_O),
        .ODP_O      (ODP_O),
        .ODN_O      (ODN_O),
        .BUSY_O     (BUSY_O),
        .ERR_O      (ERR_O)
    );

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int vb_rise   = BIG;
    int vb_fall   = BIG;
    int last_t    = 0;
    int last_idle = 0;

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // VBIAS_OK_I value sampled by edge k
    function automatic logic vb_at(input int k);
        return (k >= vb_rise) && (k < vb_fall);
    endfunction

    function automatic logic [1:0] odpn_exp(input logic [1:0] m);
        case (m)
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic step();
        logic d_prev;
        logic r_prev;
        d_prev = DATA_I;
        r_prev = RST_I;
        @(posedge CLK_I);
        cyc++;
        #1;
        chk("do", 32'(DO_O), r_prev ? 32'd0 : 32'(d_prev));
        DATA_I     = 1'($urandom_range(0, 1));
        VBIAS_OK_I = vb_at(cyc + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({DO_O, DS_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, BUSY_O, ERR_O, cfg_if.CFG_READY_O}), 32'd0);
    endtask

    // rel: edge (relative to acceptance) first sampling VBIAS high, <0 = never
    // abort_at: relative edge at which reset is pulsed, <0 = none
    // ovl: drive the ovl_cfg request {ds,sr,co,mode,en} during GOFF
    task automatic run_txn(input logic [3:0] ds, input logic sr, input logic co,
                           input logic [1:0] mode, input logic en, input int rel,
                           input int abort_at, input logic ovl, input logic [8:0] ovl_cfg);
        int t, e_apply, e_vb, gon, idle, cand;
        logic to, acc, oe_exp;
        logic [3:0] ds_exp;
        cfg_if.CFG_DS_I    = ds;
        cfg_if.CFG_SR_I    = sr;
        cfg_if.CFG_CO_I    = co;
        cfg_if.CFG_MODE_I  = mode;
        cfg_if.CFG_EN_I    = en;
        cfg_if.CFG_VALID_I = 1'b1;
        t   = -1;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            acc = cfg_if.CFG_READY_O & cfg_if.CFG_VALID_I;
            step();
            if (acc) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            chk("accept_wait", 32'(acc), 32'd1);
            cfg_if.CFG_VALID_I = 1'b0;
            return;
        end
        last_t = t;
        cfg_if.CFG_VALID_I = 1'b0;
        vb_rise    = (rel < 0) ? BIG : t + rel;
        vb_fall    = BIG;
        VBIAS_OK_I = vb_at(cyc + 1);

        e_apply = t + G + 1;
        if (ds[1:0] == 2'b00) begin
            gon = e_apply + 1;
            to  = 1'b0;
        end else begin
            e_vb = e_apply + 1;
            cand = e_vb + 1;
            if (rel >= 0 && t + rel + 2 > cand) cand = t + rel + 2;
            if (rel >= 0 && cand <= e_vb + VBT) begin
                gon = cand;
                to  = 1'b0;
            end else begin
                gon = e_vb + VBT;
                to  = 1'b1;
            end
        end
        ds_exp = to ? {ds[3:2], 2'b00} : ds;
        idle   = gon + G;
        oe_exp = en && (mode != 2'b11);

        chk("acc_err_clr", 32'(ERR_O), 32'd0);
        chk("acc_oe", 32'(OE_O), 32'd0);
        chk("acc_rdy", 32'(cfg_if.CFG_READY_O), 32'd0);
        while (cyc < idle) begin
            if (ovl && cyc == t + 2) begin
                {cfg_if.CFG_DS_I, cfg_if.CFG_SR_I, cfg_if.CFG_CO_I,
                 cfg_if.CFG_MODE_I, cfg_if.CFG_EN_I} = ovl_cfg;
                cfg_if.CFG_VALID_I = 1'b1;
            end
            if (abort_at >= 0 && cyc == t + abort_at) begin
                vb_rise    = BIG;
                VBIAS_OK_I = 1'b0;
                RST_I      = 1'b1;
                step();
                chk_all_zero("abort_rst");
                RST_I = 1'b0;
                step();
                chk("abort_rdy", 32'(cfg_if.CFG_READY_O), 32'd1);
                chk("abort_busy", 32'(BUSY_O), 32'd0);
                last_idle = cyc;
                return;
            end
            step();
            if (cyc < idle) begin
                chk("busy_oe", 32'(OE_O), 32'd0);
                chk("busy_flag", 32'(BUSY_O), 32'd1);
                chk("busy_rdy", 32'(cfg_if.CFG_READY_O), 32'd0);
            end
            if (cyc == e_apply) begin
                chk("apply_ds", 32'(DS_O), 32'(ds));
                chk("apply_srco", 32'({SR_O, CO_O}), 32'({sr, co}));
                chk("apply_odpn", 32'({ODP_O, ODN_O}), 32'(odpn_exp(mode)));
            end
            if (cyc == gon && to) begin
                chk("tmo_ds", 32'(DS_O), 32'(ds_exp));
                chk("tmo_err", 32'(ERR_O), 32'd1);
            end
        end
        chk("idle_busy", 32'(BUSY_O), 32'd0);
        chk("idle_rdy", 32'(cfg_if.CFG_READY_O), 32'd1);
        chk("idle_oe", 32'(OE_O), 32'(oe_exp));
        chk("idle_ds", 32'(DS_O), 32'(ds_exp));
        chk("idle_srco", 32'({SR_O, CO_O}), 32'({sr, co}));
        chk("idle_odpn", 32'({ODP_O, ODN_O}), 32'(odpn_exp(mode)));
        chk("idle_err", 32'(ERR_O), 32'(to));
        last_idle = idle;
    endtask

    initial begin
        int f;
        int pi;
        int rel;
        RST_I              = 1'b1;
        DATA_I             = 1'b0;
        VBIAS_OK_I         = 1'b0;
        cfg_if.CFG_VALID_I = 1'b0;
        cfg_if.CFG_DS_I    = '0;
        cfg_if.CFG_SR_I    = 1'b0;
        cfg_if.CFG_CO_I    = 1'b0;
        cfg_if.CFG_MODE_I  = '0;
        cfg_if.CFG_EN_I    = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        RST_I = 1'b0;
        step();
        chk("rst_rel_rdy", 32'(cfg_if.CFG_READY_O), 32'd1);
        chk("rst_rel_busy", 32'(BUSY_O), 32'd0);

        // weak drive, push-pull: no VBIAS wait
        run_txn(4'b0000, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1, 1'b0, 9'd0);
        // open-drain, VBIAS arrives 5 cycles into the wait
        run_txn(4'b0011, 1'b1, 1'b0, 2'b01, 1'b1, G + 2 + 5, -1, 1'b0, 9'd0);
        // VBIAS never arrives: timeout clamps DS[1:0]
        run_txn(4'b1101, 1'b0, 1'b1, 2'b00, 1'b1, -1, -1, 1'b0, 9'd0);

        // VBIAS drops while strongly driving in IDLE
        run_txn(4'b0001, 1'b0, 1'b0, 2'b00, 1'b1, 1, -1, 1'b0, 9'd0);
        repeat (2) step();
        f          = cyc + 1;
        vb_fall    = f;
        VBIAS_OK_I = vb_at(cyc + 1);
        step();
        chk("vbdrop_oe_f0", 32'(OE_O), 32'd1);
        step();
        chk("vbdrop_oe_f1", 32'(OE_O), 32'd1);
        step();
        chk("vbdrop_oe_f2", 32'(OE_O), 32'd0);
        chk("vbdrop_err", 32'(ERR_O), 32'd1);
        repeat (3) step();
        chk("vbdrop_hold_oe", 32'(OE_O), 32'd0);
        chk("vbdrop_hold_err", 32'(ERR_O), 32'd1);

        // new request arriving during GOFF is taken on the first IDLE cycle
        run_txn(4'b0100, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1, 1'b1,
                {4'b1010, 1'b1, 1'b1, 2'b10, 1'b1});
        pi = last_idle;
        run_txn(4'b1010, 1'b1, 1'b1, 2'b10, 1'b1, 3, -1, 1'b0, 9'd0);
        chk("ovl_accept_edge", 32'(last_t), 32'(pi + 1));

        // reset pulsed in the middle of VBWAIT
        run_txn(4'b0110, 1'b1, 1'b0, 2'b01, 1'b1, -1, G + 5, 1'b0, 9'd0);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) rel = -1;
            else rel = int'($urandom_range(1, G + 2 + VBT + 8));
            run_txn(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), rel, -1, 1'b0, 9'd0);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
